// File: rtl/prog_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_divider_pkg
// Brief    : Shared mode encoding and reset defaults for the programmable divider
// Revision : 1.0
// ============================================================================
package prog_divider_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_INVERT  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam int c_NUM_CH   = 4;
    localparam int c_CNT_W    = 16;
    localparam int c_DEF_DIV  = 16;
    localparam int c_DEF_DUTY = 4;

endpackage
`default_nettype wire

// File: rtl/prog_divider_ch.sv
`default_nettype none
// ============================================================================
// Module   : prog_divider_ch
// Brief    : One divider/PWM channel with active+pending config and oneshot mode
// Revision : 1.0
// ============================================================================
module prog_divider_ch
    import prog_divider_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W,
    parameter int DEF_DIV  = c_DEF_DIV,
    parameter int DEF_DUTY = c_DEF_DUTY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_duty,
    input  mode_e            i_mode,
    input  logic             i_en,
    output logic             o_clk_div,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_div_a_q,  w_div_a_d;
    logic [CNT_W-1:0] r_duty_a_q, w_duty_a_d;
    mode_e            r_mode_a_q, w_mode_a_d;
    logic [CNT_W-1:0] r_div_p_q,  w_div_p_d;
    logic [CNT_W-1:0] r_duty_p_q, w_duty_p_d;
    mode_e            r_mode_p_q, w_mode_p_d;
    logic             r_pend_q,   w_pend_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic             r_done_q,   w_done_d;
    logic             r_clk_div_q, w_clk_div_d;
    logic             r_tick_q,   w_tick_d;
    logic             w_wrap;
    logic             w_inv;

    assign w_wrap = i_en && !r_done_q && (r_cnt_q == (r_div_a_q - CNT_W'(1)));
    assign w_inv  = (r_mode_a_q == MODE_INVERT);

    always_comb begin
        w_div_a_d   = r_div_a_q;
        w_duty_a_d  = r_duty_a_q;
        w_mode_a_d  = r_mode_a_q;
        w_div_p_d   = r_div_p_q;
        w_duty_p_d  = r_duty_p_q;
        w_mode_p_d  = r_mode_p_q;
        w_pend_d    = r_pend_q;
        w_cnt_d     = r_cnt_q;
        w_done_d    = r_done_q;
        w_clk_div_d = r_clk_div_q;
        w_tick_d    = 1'b0;

        // Apply the old pending set before capturing a new write, so a write
        // landing on a wrap edge waits for the next wrap.
        if (r_pend_q && (w_wrap || !i_en)) begin
            w_div_a_d  = r_div_p_q;
            w_duty_a_d = r_duty_p_q;
            w_mode_a_d = r_mode_p_q;
            w_pend_d   = 1'b0;
        end
        if (i_wr) begin
            w_div_p_d  = i_div;
            w_duty_p_d = i_duty;
            w_mode_p_d = i_mode;
            w_pend_d   = 1'b1;
        end

        if (!i_en) begin
            w_cnt_d     = '0;
            w_clk_div_d = w_inv;
            w_done_d    = 1'b0;
        end else if (r_done_q) begin
            w_cnt_d     = '0;
            w_clk_div_d = 1'b0;
        end else begin
            w_clk_div_d = (r_cnt_q < r_duty_a_q) ^ w_inv;
            w_cnt_d     = w_wrap ? '0 : r_cnt_q + CNT_W'(1);
            w_tick_d    = w_wrap;
            if (w_wrap && (r_mode_a_q == MODE_ONESHOT)) begin
                w_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_a_q   <= CNT_W'(DEF_DIV);
            r_duty_a_q  <= CNT_W'(DEF_DUTY);
            r_mode_a_q  <= MODE_FREE;
            r_div_p_q   <= CNT_W'(DEF_DIV);
            r_duty_p_q  <= CNT_W'(DEF_DUTY);
            r_mode_p_q  <= MODE_FREE;
            r_pend_q    <= 1'b0;
            r_cnt_q     <= '0;
            r_done_q    <= 1'b0;
            r_clk_div_q <= 1'b0;
            r_tick_q    <= 1'b0;
        end else begin
            r_div_a_q   <= w_div_a_d;
            r_duty_a_q  <= w_duty_a_d;
            r_mode_a_q  <= w_mode_a_d;
            r_div_p_q   <= w_div_p_d;
            r_duty_p_q  <= w_duty_p_d;
            r_mode_p_q  <= w_mode_p_d;
            r_pend_q    <= w_pend_d;
            r_cnt_q     <= w_cnt_d;
            r_done_q    <= w_done_d;
            r_clk_div_q <= w_clk_div_d;
            r_tick_q    <= w_tick_d;
        end
    end

    assign o_clk_div = r_clk_div_q;
    assign o_tick    = r_tick_q;

endmodule
`default_nettype wire

// File: rtl/prog_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_divider
// Brief    : Multi-channel programmable clock divider / PWM with config decode
// Revision : 1.0
// ============================================================================
module prog_divider
    import prog_divider_pkg::*;
#(
    parameter int NUM_CH   = c_NUM_CH,
    parameter int CNT_W    = c_CNT_W,
    parameter int DEF_DIV  = c_DEF_DIV,
    parameter int DEF_DUTY = c_DEF_DUTY,
    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [c_CH_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [1:0]        cfg_mode,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] period_tick
);

    logic  w_ch_ok;
    logic  w_cfg_bad;
    logic  w_wr_ok;
    logic  r_cfg_err_q, w_cfg_err_d;
    mode_e w_mode;

    assign w_ch_ok   = (int'(cfg_ch) < NUM_CH);
    assign w_cfg_bad = (cfg_div == '0) || !w_ch_ok;
    assign w_wr_ok   = cfg_wr && !w_cfg_bad;
    assign w_mode    = mode_e'(cfg_mode);

    always_comb begin
        w_cfg_err_d = cfg_wr && w_cfg_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err_q <= 1'b0;
        end else begin
            r_cfg_err_q <= w_cfg_err_d;
        end
    end

    assign cfg_err = r_cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        prog_divider_ch #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_DUTY (DEF_DUTY)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_wr      (w_wr_ok && (int'(cfg_ch) == g)),
            .i_div     (cfg_div),
            .i_duty    (cfg_duty),
            .i_mode    (w_mode),
            .i_en      (en[g]),
            .o_clk_div (clk_div[g]),
            .o_tick    (period_tick[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_divider
// Brief    : Directed self-checking bench for prog_divider
// Revision : 1.0
// ============================================================================
module tb_prog_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_duty;
    logic [1:0]  cfg_mode;
    logic        cfg_err;
    logic [3:0]  en;
    logic [3:0]  clk_div;
    logic [3:0]  period_tick;

    // Second instance with a non-power-of-two channel count for range rejection
    logic        cfg_wr3;
    logic [1:0]  cfg_ch3;
    logic        cfg_err3;
    logic [2:0]  en3;
    logic [2:0]  clk_div3;
    logic [2:0]  period_tick3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_divider u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_duty    (cfg_duty),
        .cfg_mode    (cfg_mode),
        .cfg_err     (cfg_err),
        .en          (en),
        .clk_div     (clk_div),
        .period_tick (period_tick)
    );

    prog_divider #(.NUM_CH(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr3),
        .cfg_ch      (cfg_ch3),
        .cfg_div     (cfg_div),
        .cfg_duty    (cfg_duty),
        .cfg_mode    (cfg_mode),
        .cfg_err     (cfg_err3),
        .en          (en3),
        .clk_div     (clk_div3),
        .period_tick (period_tick3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; en3 = '0; cfg_wr = 1'b0; cfg_wr3 = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] div,
                             input logic [15:0] duty, input logic [1:0] mode);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_div = div; cfg_duty = duty; cfg_mode = mode;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 4'hF; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0;
        cfg_duty = 16'd0; cfg_mode = 2'b10; cfg_wr3 = 1'b0; en3 = '0;
        step(); step();
        total++;
        if (clk_div !== 4'h0) begin
            bad++; $display("FAIL reset_clk_div got=%h exp=0", clk_div);
        end
        total++;
        if (period_tick !== 4'h0) begin
            bad++; $display("FAIL reset_tick got=%h exp=0", period_tick);
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err);
        end
        cfg_wr = 1'b0; rst = 1'b0; en = '0;
    endtask

    task automatic test_default();
        do_reset();
        en = 4'b0001;
        for (int k = 1; k <= 32; k++) begin
            step();
            total++;
            if (clk_div[0] !== (((k - 1) % 16) < 4)) begin
                bad++; $display("FAIL default_clk_div k=%0d got=%b", k, clk_div[0]);
            end
            total++;
            if (period_tick[0] !== ((k % 16) == 0)) begin
                bad++; $display("FAIL default_tick k=%0d got=%b", k, period_tick[0]);
            end
            total++;
            if (clk_div[3:1] !== 3'b000) begin
                bad++; $display("FAIL default_idle_ch k=%0d got=%b exp=000", k, clk_div[3:1]);
            end
        end
    endtask

    task automatic test_apply_mid();
        logic exp_d;
        logic exp_t;
        do_reset();
        en = 4'b0011;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 7) begin
                cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5; cfg_duty = 16'd2; cfg_mode = 2'b00;
            end else begin
                cfg_wr = 1'b0;
            end
            if (k <= 16) begin
                exp_d = ((k - 1) % 16) < 4;
                exp_t = (k % 16) == 0;
            end else begin
                exp_d = ((k - 17) % 5) < 2;
                exp_t = ((k - 17) % 5) == 4;
            end
            total++;
            if (clk_div[1] !== exp_d) begin
                bad++; $display("FAIL apply_clk_div k=%0d got=%b exp=%b", k, clk_div[1], exp_d);
            end
            total++;
            if (period_tick[1] !== exp_t) begin
                bad++; $display("FAIL apply_tick k=%0d got=%b exp=%b", k, period_tick[1], exp_t);
            end
            total++;
            if (clk_div[0] !== (((k - 1) % 16) < 4)) begin
                bad++; $display("FAIL apply_neighbour k=%0d got=%b", k, clk_div[0]);
            end
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL apply_cfg_err got=%b exp=0", cfg_err);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        cfg_write(2'd0, 16'd16, 16'd0, 2'b00);
        step();
        en = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if (clk_div[0] !== 1'b0) begin
                bad++; $display("FAIL duty0 k=%0d got=%b exp=0", k, clk_div[0]);
            end
        end
        en = 4'b0000;
        step();
        cfg_write(2'd0, 16'd5, 16'd8, 2'b00);
        step();
        en = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if (clk_div[0] !== 1'b1) begin
                bad++; $display("FAIL duty_ge_div k=%0d got=%b exp=1", k, clk_div[0]);
            end
            total++;
            if (period_tick[0] !== ((k % 5) == 0)) begin
                bad++; $display("FAIL duty_ge_div_tick k=%0d got=%b", k, period_tick[0]);
            end
        end
        en = 4'b0000;
        step();
        cfg_write(2'd0, 16'd1, 16'd1, 2'b10);
        step();
        step();
        total++;
        if (clk_div[0] !== 1'b1) begin
            bad++; $display("FAIL invert_idle got=%b exp=1", clk_div[0]);
        end
        en = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (clk_div[0] !== 1'b0) begin
                bad++; $display("FAIL div1_inv k=%0d got=%b exp=0", k, clk_div[0]);
            end
            total++;
            if (period_tick[0] !== 1'b1) begin
                bad++; $display("FAIL div1_tick k=%0d got=%b exp=1", k, period_tick[0]);
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        cfg_write(2'd2, 16'd6, 16'd3, 2'b01);
        step();
        for (int rep = 0; rep < 2; rep++) begin
            en = 4'b0100;
            for (int k = 1; k <= 12; k++) begin
                step();
                total++;
                if (clk_div[2] !== (k <= 3)) begin
                    bad++; $display("FAIL oneshot_clk_div rep=%0d k=%0d got=%b", rep, k, clk_div[2]);
                end
                total++;
                if (period_tick[2] !== (k == 6)) begin
                    bad++; $display("FAIL oneshot_tick rep=%0d k=%0d got=%b", rep, k, period_tick[2]);
                end
            end
            en = 4'b0000;
            step();
            total++;
            if (clk_div[2] !== 1'b0) begin
                bad++; $display("FAIL oneshot_idle rep=%0d got=%b exp=0", rep, clk_div[2]);
            end
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        en = 4'b0001;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 3) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0; cfg_duty = 16'd1; cfg_mode = 2'b00;
            end else if (k == 10) begin
                cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7; cfg_duty = 16'd1; cfg_mode = 2'b00;
            end else begin
                cfg_wr = 1'b0;
            end
            total++;
            if (cfg_err !== (k == 4)) begin
                bad++; $display("FAIL err_div0 k=%0d got=%b exp=%b", k, cfg_err, (k == 4));
            end
            total++;
            if (clk_div[0] !== (((k - 1) % 16) < 4)) begin
                bad++; $display("FAIL err_unchanged k=%0d got=%b", k, clk_div[0]);
            end
        end
        en = 4'b0000;
        cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 16'd5; cfg_duty = 16'd2; cfg_mode = 2'b00;
        step();
        cfg_wr3 = 1'b0;
        total++;
        if (cfg_err3 !== 1'b1) begin
            bad++; $display("FAIL err_ch_range got=%b exp=1", cfg_err3);
        end
        step();
        total++;
        if (cfg_err3 !== 1'b0) begin
            bad++; $display("FAIL err_ch_pulse got=%b exp=0", cfg_err3);
        end
        cfg_wr3 = 1'b1; cfg_ch3 = 2'd2;
        step();
        cfg_wr3 = 1'b0;
        total++;
        if (cfg_err3 !== 1'b0) begin
            bad++; $display("FAIL err_ch_valid got=%b exp=0", cfg_err3);
        end
        step();
        en3 = 3'b100;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if (clk_div3[2] !== (((k - 1) % 5) < 2)) begin
                bad++; $display("FAIL ch3_pattern k=%0d got=%b", k, clk_div3[2]);
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        en = 4'b0001;
        for (int k = 1; k <= 9; k++) step();
        cfg_write(2'd0, 16'd5, 16'd2, 2'b00);
        rst = 1'b1;
        step();
        total++;
        if ({clk_div, period_tick, cfg_err} !== 9'h000) begin
            bad++; $display("FAIL rst_mid got=%h exp=000", {clk_div, period_tick, cfg_err});
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            total++;
            if (clk_div[0] !== (((k - 1) % 16) < 4)) begin
                bad++; $display("FAIL rst_resume k=%0d got=%b", k, clk_div[0]);
            end
            total++;
            if (period_tick[0] !== ((k % 16) == 0)) begin
                bad++; $display("FAIL rst_resume_tick k=%0d got=%b", k, period_tick[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_duty = '0;
        cfg_mode = '0; en = '0; cfg_wr3 = 1'b0; cfg_ch3 = '0; en3 = '0;
        test_reset();
        test_default();
        test_apply_mid();
        test_boundary();
        test_oneshot();
        test_cfg_err();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
